// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder.
// Holds the FSM state encoding, the digit-counter width rule and the WIDTH/DIGIT legality check.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dsa_state_e;

    // A single-digit configuration still gets a 1-bit counter, which is then held at zero.
    function automatic int dsa_cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit dsa_params_ok(input int width, input int digit);
        if (width < 1 || digit < 1 || digit > width) begin
            return 1'b0;
        end
        return (width % digit) == 0;
    endfunction

endpackage

// File: rtl/adder_digit.sv
// Combinational DIGIT-bit ripple-carry slice used once per clock by digit_serial_adder.
// Also exposes the carry into the top bit so the caller can derive signed overflow.
module adder_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    always_comb begin
        logic c_ripple;
        // NOTE: blocking assignments here model the ripple: each bit must see the carry from the bit below within the same evaluation.
        c_ripple = ci;
        c_msb_in = ci;
        s        = '0;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) begin
                c_msb_in = c_ripple;
            end
            s[i]     = a[i] ^ b[i] ^ c_ripple;
            c_ripple = (a[i] & b[i]) | (c_ripple & (a[i] ^ b[i]));
        end
        co = c_ripple;
    end

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial add/subtract: WIDTH-bit operands processed DIGIT bits per clock, LSB digit first.
// Optional signed-overflow output `ovf` is enabled by defining DIGIT_SERIAL_ADDER_OVF_EN.
module digit_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = (DIGIT >= 1) ? WIDTH / DIGIT : 1;
    localparam int CW = dsa_cnt_width(N);

    if (!dsa_params_ok(WIDTH, DIGIT)) begin : g_param_check
        $fatal(1, "digit_serial_adder: illegal WIDTH=%0d DIGIT=%0d", WIDTH, DIGIT);
    end

    dsa_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [DIGIT-1:0] dig_s;
    logic             dig_co;
    logic             dig_cmsb;
    logic [WIDTH-1:0] res_shift;
    logic             last_digit;

    adder_digit #(
        .DIGIT(DIGIT)
    ) u_digit (
        .a       (a_q[DIGIT-1:0]),
        .b       (b_q[DIGIT-1:0]),
        .ci      (carry_q),
        .s       (dig_s),
        .co      (dig_co),
        .c_msb_in(dig_cmsb)
    );

    // New digit enters at the top; after N shifts the first digit has reached bit 0.
    assign res_shift  = WIDTH'({dig_s, res_q} >> DIGIT);
    assign last_digit = (cnt_q == CW'(N - 1));

`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    logic ovf_q, ovf_d;
`else
    logic unused_cmsb;
    assign unused_cmsb = dig_cmsb;
`endif

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case can infer a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = sub ? ~op_b : op_b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                res_d   = res_shift;
                carry_d = dig_co;
                cnt_d   = (N == 1) ? '0 : cnt_q + 1'b1;
                if (last_digit) begin
                    sum_d   = res_shift;
                    cout_d  = dig_co;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
                    ovf_d   = dig_cmsb ^ dig_co;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the operand and result shift registers are reset too, so a dropped operation leaves no stale digits behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboard bench for digit_serial_adder: three configurations (16/4, 8/1, 16/16) share one clock and reset.
// Expected results come from plain integer arithmetic; a negedge monitor pops and compares on each delivery.
module tb_digit_serial_adder;

    typedef struct {
        int          idx;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    localparam int ND [3] = '{4, 8, 1};
    localparam int WD [3] = '{16, 8, 16};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        in_valid_v  [3];
    logic        out_ready_v [3];
    logic        cin_v       [3];
    logic        sub_v       [3];
    logic [15:0] op_a_v      [3];
    logic [15:0] op_b_v      [3];
    logic        in_ready_v  [3];
    logic        out_valid_v [3];
    logic        cout_v      [3];
    logic [15:0] sum_v       [3];

    logic        in_ready0, in_ready1, in_ready2;
    logic        out_valid0, out_valid1, out_valid2;
    logic        cout0, cout1, cout2;
    logic [15:0] sum0, sum2;
    logic [7:0]  sum1;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    logic        ovf0, ovf1, ovf2;
    logic        ovf_v [3];
`endif

    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut_d4 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready0),
        .op_a(op_a_v[0]), .op_b(op_b_v[0]), .cin(cin_v[0]), .sub(sub_v[0]),
        .out_valid(out_valid0), .out_ready(out_ready_v[0]), .sum(sum0), .cout(cout0)
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        , .ovf(ovf0)
`endif
    );

    digit_serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready1),
        .op_a(op_a_v[1][7:0]), .op_b(op_b_v[1][7:0]), .cin(cin_v[1]), .sub(sub_v[1]),
        .out_valid(out_valid1), .out_ready(out_ready_v[1]), .sum(sum1), .cout(cout1)
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        , .ovf(ovf1)
`endif
    );

    digit_serial_adder #(.WIDTH(16), .DIGIT(16)) u_dut_d16 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready2),
        .op_a(op_a_v[2]), .op_b(op_b_v[2]), .cin(cin_v[2]), .sub(sub_v[2]),
        .out_valid(out_valid2), .out_ready(out_ready_v[2]), .sum(sum2), .cout(cout2)
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        , .ovf(ovf2)
`endif
    );

    always_comb begin
        in_ready_v[0]  = in_ready0;  in_ready_v[1]  = in_ready1;  in_ready_v[2]  = in_ready2;
        out_valid_v[0] = out_valid0; out_valid_v[1] = out_valid1; out_valid_v[2] = out_valid2;
        cout_v[0]      = cout0;      cout_v[1]      = cout1;      cout_v[2]      = cout2;
        sum_v[0]       = sum0;       sum_v[1]       = {8'h00, sum1}; sum_v[2]    = sum2;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        ovf_v[0] = ovf0; ovf_v[1] = ovf1; ovf_v[2] = ovf2;
`endif
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: integer arithmetic on the operand values, signed overflow from the true signed result's range.
    function automatic exp_t model(input int k, input logic [15:0] a, input logic [15:0] b,
                                   input logic c, input logic s);
        exp_t   e;
        longint md, ua, ub, r, sa, sb, sr;
        md = longint'(1) << WD[k];
        ua = longint'(a) & (md - 1);
        ub = longint'(b) & (md - 1);
        if (s) begin
            r      = ua - ub;
            e.cout = (ua >= ub);
        end else begin
            r      = ua + ub + longint'(c);
            e.cout = (r >= md);
        end
        e.idx = k;
        e.sum = 16'(r & (md - 1));
        sa    = (ua >= md / 2) ? ua - md : ua;
        sb    = (ub >= md / 2) ? ub - md : ub;
        sr    = s ? sa - sb : sa + sb + longint'(c);
        e.ovf = (sr < -(md / 2)) || (sr >= md / 2);
        return e;
    endfunction

    int   acc_edge [3];
    bit   ov_prev  [3];
    exp_t mon_e;

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                ov_prev[k] = 1'b0;
            end else begin
                if (in_valid_v[k] && in_ready_v[k]) acc_edge[k] = cyc + 1;
                if (out_valid_v[k] && !ov_prev[k]) begin
                    check($sformatf("pending_on_valid[%0d]", k), 32'(sb_q.size() != 0), 32'd1);
                    check($sformatf("latency[%0d]", k), cyc - acc_edge[k], ND[k]);
                end
                if (out_valid_v[k] && out_ready_v[k]) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result[%0d]: got sum %0h expected no result", k, sum_v[k]);
                    end else begin
                        mon_e = sb_q.pop_front();
                        check($sformatf("result_owner[%0d]", k), k, mon_e.idx);
                        check($sformatf("sum[%0d]", k), sum_v[k], mon_e.sum);
                        check($sformatf("cout[%0d]", k), cout_v[k], mon_e.cout);
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
                        check($sformatf("ovf[%0d]", k), ovf_v[k], mon_e.ovf);
`endif
                    end
                end
                ov_prev[k] = out_valid_v[k];
            end
        end
    end

    task automatic send(input int k, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic s);
        int t = 0;
        op_a_v[k] = a; op_b_v[k] = b; cin_v[k] = c; sub_v[k] = s;
        in_valid_v[k] = 1'b1;
        @(negedge clk);
        while (!in_ready_v[k]) begin
            if (++t > 100) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout[%0d]: got in_ready 0 expected 1", k);
                in_valid_v[k] = 1'b0;
                return;
            end
            @(negedge clk);
        end
        sb_q.push_back(model(k, a, b, c, s));
        @(posedge clk); #1;
        in_valid_v[k] = 1'b0;
    endtask

    task automatic drain(input int k, input bit rnd);
        int t = 0;
        forever begin
            out_ready_v[k] = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge clk);
            if (out_valid_v[k] && out_ready_v[k]) break;
            @(posedge clk); #1;
            if (++t > 200) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout[%0d]: got out_valid 0 expected 1", k);
                out_ready_v[k] = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        out_ready_v[k] = 1'b0;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t bp;
        int   t;
        for (int k = 0; k < 3; k++) begin
            in_valid_v[k] = 1'b0; out_ready_v[k] = 1'b0; cin_v[k] = 1'b0; sub_v[k] = 1'b0;
            op_a_v[k] = '0; op_b_v[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_in_ready[%0d]", k), in_ready_v[k], 1);
            check($sformatf("rst_out_valid[%0d]", k), out_valid_v[k], 0);
            check($sformatf("rst_sum[%0d]", k), sum_v[k], 0);
            check($sformatf("rst_cout[%0d]", k), cout_v[k], 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready0, 1);
        @(posedge clk); #1;

        // Directed vectors on the 16/4 instance, including carry-out, borrow and overflow corners.
        send(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0); drain(0, 0);
        send(0, 16'h0005, 16'h0007, 1'b0, 1'b1); drain(0, 0);
        send(0, 16'h0007, 16'h0005, 1'b1, 1'b1); drain(0, 0);
        send(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0); drain(0, 0);
        send(0, 16'h8000, 16'h0001, 1'b0, 1'b1); drain(0, 0);
        send(0, 16'h0003, 16'h0004, 1'b0, 1'b0); drain(0, 0);

        // Backpressure: result held with out_ready low while in_valid pulses are ignored.
        bp = model(0, 16'h1234, 16'h4321, 1'b0, 1'b0);
        send(0, 16'h1234, 16'h4321, 1'b0, 1'b0);
        t = 0;
        @(negedge clk);
        while (!out_valid0 && t < 50) begin
            t++;
            @(negedge clk);
        end
        check("bp_reached_done", out_valid0, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid_v[0] = 1'b1;
            op_a_v[0] = 16'($urandom);
            @(negedge clk);
            check($sformatf("bp_sum_hold[%0d]", i), sum0, bp.sum);
            check($sformatf("bp_cout_hold[%0d]", i), cout0, bp.cout);
            check($sformatf("bp_out_valid[%0d]", i), out_valid0, 1);
            check($sformatf("bp_in_ready[%0d]", i), in_ready0, 0);
        end
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        out_ready_v[0] = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        out_ready_v[0] = 1'b0;
        @(negedge clk);
        check("bp_release_in_ready", in_ready0, 1);
        check("bp_release_out_valid", out_valid0, 0);
        @(posedge clk); #1;

        // Reset while digit 2 is in flight: operation dropped, state cleared at once.
        send(0, 16'h1234, 16'h1111, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        sb_q.delete();
        check("rst_mid_out_valid", out_valid0, 0);
        check("rst_mid_sum", sum0, 0);
        check("rst_mid_in_ready", in_ready0, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_rel_in_ready", in_ready0, 1);
        check("rst_rel_out_valid", out_valid0, 0);
        repeat (8) @(negedge clk);
        @(posedge clk); #1;
        send(0, 16'h1234, 16'h1111, 1'b0, 1'b0); drain(0, 0);

        for (int i = 0; i < 30; i++) begin
            send(0, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            drain(0, 1);
        end

        // Bit-serial 8/1 instance.
        send(1, 16'h00AA, 16'h0055, 1'b1, 1'b0); drain(1, 0);
        for (int i = 0; i < 12; i++) begin
            send(1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            drain(1, 1);
        end

        // Single-digit 16/16 instance.
        send(2, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0); drain(2, 0);
        for (int i = 0; i < 15; i++) begin
            send(2, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            drain(2, 1);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
